// File: rtl/ssd1306_spi_tx_pkg.sv
// Shared definitions for the SSD1306 SPI transmitter: FSM state encodings,
// D/C# line constants shared with the ssd1306 receiver, and width helpers.
package ssd1306_spi_tx_pkg;

  typedef enum logic [2:0] {
    SSD1306_TX_RST_LOW  = 3'd0,
    SSD1306_TX_RST_WAIT = 3'd1,
    SSD1306_TX_IDLE     = 3'd2,
    SSD1306_TX_SHIFT    = 3'd3,
    SSD1306_TX_CS_HOLD  = 3'd4
  } tx_state_e;

  localparam logic SSD1306_DC_CMD  = 1'b0;
  localparam logic SSD1306_DC_DATA = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A counter for n states still needs one bit when n is 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd1306_spi_phase.sv
// SCL phase and bit counters: each bit is CLK_DIV low cycles then CLK_DIV
// high cycles; strobes mark the cycle before SCL rises or falls.
module ssd1306_spi_phase
  import ssd1306_spi_tx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic load_i,
  output logic fall_en_o,
  output logic rise_en_o,
  output logic last_cycle_o
);

  localparam int PW = cnt_width(CLK_DIV);

  logic [PW-1:0] phase_q;
  logic          high_q;
  logic [2:0]    bit_q;
  logic          phase_end;

  assign phase_end    = run_i && (phase_q == PW'(CLK_DIV - 1));
  assign rise_en_o    = phase_end && !high_q;
  assign fall_en_o    = phase_end && high_q;
  assign last_cycle_o = fall_en_o && (bit_q == 3'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      phase_q <= '0;
      high_q  <= 1'b0;
      bit_q   <= 3'd7;
    end else if (load_i) begin
      phase_q <= '0;
      high_q  <= 1'b0;
      bit_q   <= 3'd7;
    end else if (!run_i) begin
      phase_q <= '0;
      high_q  <= 1'b0;
    end else if (phase_end) begin
      phase_q <= '0;
      high_q  <= !high_q;
      if (high_q) bit_q <= bit_q - 3'd1;
    end else begin
      phase_q <= phase_q + PW'(1);
    end
  end

endmodule

// File: rtl/ssd1306_spi_tx.sv
// SSD1306 4-wire SPI transmitter: sequences the panel RES# pulse, then
// serializes command/data bytes MSB first in SPI mode 0.
module ssd1306_spi_tx
  import ssd1306_spi_tx_pkg::*;
#(
  parameter int CLK_DIV            = 4,
  parameter int RST_PULSE_CYCLES   = 160,
  parameter int RST_RECOVER_CYCLES = 1600
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       oled_init_i,
  input  logic [7:0] s_data_i,
  input  logic       s_dc_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic       busy_o,
  output logic       scl_o,
  output logic       mosi_o,
  output logic       cs_o,
  output logic       dc_o,
  output logic       oled_rst_o,
  output tx_state_e  state_o
);

  localparam int TW = $clog2(max3(RST_PULSE_CYCLES, RST_RECOVER_CYCLES, CLK_DIV) + 1);

  tx_state_e     state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [7:0]    shreg_q;
  logic          dc_q, scl_q;
  logic          hs, in_shift, fall_en, rise_en, last_cycle;

  // Handshake: a byte moves when s_valid_i and s_ready_o are both high on the
  // same rising edge; ready never depends on valid, and valid must hold until then.
  assign in_shift  = (state_q == SSD1306_TX_SHIFT);
  assign s_ready_o = (state_q == SSD1306_TX_IDLE) || (in_shift && last_cycle);
  assign hs        = s_valid_i && s_ready_o;

  ssd1306_spi_phase #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .run_i        (in_shift),
    .load_i       (hs),
    .fall_en_o    (fall_en),
    .rise_en_o    (rise_en),
    .last_cycle_o (last_cycle)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      SSD1306_TX_RST_LOW:
        if (timer_q == TW'(RST_PULSE_CYCLES - 1)) state_d = SSD1306_TX_RST_WAIT;
      SSD1306_TX_RST_WAIT:
        if (timer_q == TW'(RST_RECOVER_CYCLES - 1)) state_d = SSD1306_TX_IDLE;
      SSD1306_TX_IDLE:
        if (hs)               state_d = SSD1306_TX_SHIFT;
        else if (oled_init_i) state_d = SSD1306_TX_RST_LOW;
      SSD1306_TX_SHIFT:
        if (last_cycle && !s_valid_i) state_d = SSD1306_TX_CS_HOLD;
      SSD1306_TX_CS_HOLD:
        if (timer_q == TW'(CLK_DIV - 1)) state_d = SSD1306_TX_IDLE;
      default: state_d = SSD1306_TX_RST_LOW;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= SSD1306_TX_RST_LOW;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      // Timer only runs in the timed states and restarts on every entry.
      if (state_d != state_q || state_q == SSD1306_TX_IDLE || state_q == SSD1306_TX_SHIFT)
        timer_q <= '0;
      else
        timer_q <= timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      shreg_q <= 8'h00;
      dc_q    <= SSD1306_DC_CMD;
      scl_q   <= 1'b0;
    end else begin
      if (hs) begin
        shreg_q <= s_data_i;
        dc_q    <= s_dc_i;
      end else if (fall_en && !last_cycle) begin
        shreg_q <= {shreg_q[6:0], 1'b0};
      end
      if (rise_en)      scl_q <= 1'b1;
      else if (fall_en) scl_q <= 1'b0;
    end
  end

  assign busy_o     = (state_q != SSD1306_TX_IDLE);
  assign scl_o      = scl_q;
  assign mosi_o     = shreg_q[7];
  assign cs_o       = !(in_shift || state_q == SSD1306_TX_CS_HOLD);
  assign dc_o       = dc_q;
  assign oled_rst_o = (state_q != SSD1306_TX_RST_LOW);
  assign state_o    = state_q;

endmodule

// File: tb/tb_ssd1306_spi_tx.sv
// Directed bench for ssd1306_spi_tx: cycle-accurate pin waveforms plus an
// SPI receiver model feeding a byte scoreboard.
module tb_ssd1306_spi_tx;
  import ssd1306_spi_tx_pkg::*;

  localparam int D        = 2;
  localparam int PULSE    = 4;
  localparam int RECOVER  = 8;
  localparam int BYTE_CYC = 16 * D;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       oled_init_i = 1'b0;
  logic [7:0] s_data_i = 8'h00;
  logic       s_dc_i = 1'b0;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o, busy_o, scl_o, mosi_o, cs_o, dc_o, oled_rst_o;
  tx_state_e  state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  ssd1306_spi_tx #(
    .CLK_DIV            (D),
    .RST_PULSE_CYCLES   (PULSE),
    .RST_RECOVER_CYCLES (RECOVER)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .oled_init_i (oled_init_i),
    .s_data_i    (s_data_i),
    .s_dc_i      (s_dc_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .busy_o      (busy_o),
    .scl_o       (scl_o),
    .mosi_o      (mosi_o),
    .cs_o        (cs_o),
    .dc_o        (dc_o),
    .oled_rst_o  (oled_rst_o),
    .state_o     (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- receiver model / scoreboard ----------------
  logic       scl_prev = 1'b0;
  logic [7:0] rx_sh = 8'h00;
  int         rx_bits = 0;
  int         aborted_bits = -1;
  int         edges = 0;

  always @(negedge clk) begin
    if (scl_o && !scl_prev) edges++;
    if (cs_o) begin
      if (rx_bits != 0) aborted_bits = rx_bits;
      rx_bits = 0;
    end else if (scl_o && !scl_prev) begin
      rx_sh = {rx_sh[6:0], mosi_o};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_bits = 0;
        check("sb_qdepth", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("sb_byte", {dc_o, rx_sh}, exp_q.pop_front());
      end
    end
    scl_prev = scl_o;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Entered on cycle 0 of a RES# sequence; leaves on the first IDLE cycle.
  task automatic check_rst_seq(input string tag);
    for (int c = 0; c <= PULSE + RECOVER; c++) begin
      if (c > 0) wait_cycle();
      check($sformatf("%s_c%0d", tag, c),
            {oled_rst_o, s_ready_o, busy_o, cs_o, scl_o},
            {(c >= PULSE), (c == PULSE + RECOVER), (c < PULSE + RECOVER), 1'b1, 1'b0});
    end
  endtask

  // Sends n (1 or 2) bytes from IDLE; the second byte's valid rises at cycle gap.
  task automatic send_wave(input string tag, input int n,
                           input logic [7:0] b0, input logic d0,
                           input logic [7:0] b1, input logic d1,
                           input int gap, input logic init);
    int s, len, k, bitpos;
    logic [7:0] cur;
    logic cur_dc, e_scl, e_mosi, e_cs, e_ready, e_busy;
    s   = n * BYTE_CYC;
    len = s + D + 2;
    check({tag, "_idle_ready"}, s_ready_o, 1);
    s_data_i    = b0;
    s_dc_i      = d0;
    s_valid_i   = 1'b1;
    oled_init_i = init;
    exp_q.push_back({d0, b0});
    if (n == 2) exp_q.push_back({d1, b1});
    for (int c = 1; c <= len; c++) begin
      wait_cycle();
      k      = (c <= s) ? (c - 1) / BYTE_CYC : n - 1;
      cur    = (k == 0) ? b0 : b1;
      cur_dc = (k == 0) ? d0 : d1;
      bitpos = 7 - ((c - 1) % BYTE_CYC) / (2 * D);
      e_scl   = (c <= s) && (((c - 1) % (2 * D)) >= D);
      e_mosi  = (c <= s) ? cur[bitpos] : cur[0];
      e_cs    = (c > s + D);
      e_ready = ((c <= s) && (c % BYTE_CYC == 0)) || (c > s + D);
      e_busy  = (c <= s + D);
      check($sformatf("%s_c%0d", tag, c),
            {cs_o, scl_o, mosi_o, dc_o, s_ready_o, busy_o, oled_rst_o},
            {e_cs, e_scl, e_mosi, cur_dc, e_ready, e_busy, 1'b1});
      if (c == 1) begin
        oled_init_i = 1'b0;
        if (n == 1) s_valid_i = 1'b0;
        else begin
          s_data_i  = b1;
          s_dc_i    = d1;
          s_valid_i = (gap <= 1);
        end
      end
      if (n == 2 && c == gap && gap > 1) s_valid_i = 1'b1;
      if (c == BYTE_CYC + 1) s_valid_i = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int e0;
    repeat (3) wait_cycle();
    check("rst_pins", {scl_o, mosi_o, cs_o, dc_o, oled_rst_o, s_ready_o, busy_o}, 7'b0010001);
    check("rst_state", state, SSD1306_TX_RST_LOW);
    rst_i = 1'b1;
    check_rst_seq("por");

    send_wave("single", 1, 8'hA5, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    send_wave("burst",  2, 8'h3C, 1'b1, 8'hC3, 1'b0, 1, 1'b0);
    send_wave("bp",     2, 8'h0F, 1'b0, 8'h81, 1'b1, 10, 1'b0);

    // Abort at the 4th rising SCL edge
    check("abort_idle_ready", s_ready_o, 1);
    s_data_i  = 8'h5A;
    s_dc_i    = 1'b0;
    s_valid_i = 1'b1;
    wait_cycle();
    s_valid_i = 1'b0;
    for (int c = 2; c <= 15; c++) wait_cycle();
    check("abort_scl_high", scl_o, 1);
    rst_i = 1'b0;
    wait_cycle();
    check("abort_pins", {cs_o, scl_o, oled_rst_o, busy_o, s_ready_o, mosi_o, dc_o}, 7'b1001000);
    e0 = edges;
    rst_i = 1'b1;
    check_rst_seq("abort_rst");
    check("abort_bits", aborted_bits, 4);
    check("abort_edges", edges, e0);

    // Init alone reruns RES#; init with a byte is ignored
    check("init_idle_ready", s_ready_o, 1);
    oled_init_i = 1'b1;
    wait_cycle();
    oled_init_i = 1'b0;
    check_rst_seq("init");
    send_wave("init_hs", 1, 8'h96, 1'b1, 8'h00, 1'b0, 0, 1'b1);

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_tx.md
# ssd1306_spi_tx

Transmit-side SSD1306 OLED link: serializes command/data bytes from the core into the 4-wire SPI protocol (SCL, MOSI, CS#, D/C#) that the on-chip `ssd1306` raster receiver consumes. Also sequences the OLED RES# pulse. It drives a physical SSD1306 panel when `USE_EXTERNAL_SSD1306` is `"TRUE"`, or feeds the internal receiver in loopback benches. Sits between a byte-stream producer (MCU SPI shim or display DMA) and the `ja` OLED pins.

## Interface
- `CLK_DIV`, 4: SCL half-period in `clk_i` cycles; minimum 1.
- `RST_PULSE_CYCLES`, 160: RES# low time (10 µs at 16 MHz).
- `RST_RECOVER_CYCLES`, 1600: wait after RES# release before first byte is accepted.
- `clk_i`  in  1  single system clock (`sys_clk`).
- `rst_i`  in  1  synchronous, active-low reset.
- `oled_init_i`  in  1  request to rerun the RES# sequence; sampled only in IDLE.
- `s_data_i`  in  8  byte to send, MSB first.
- `s_dc_i`  in  1  0 = command, 1 = display data.
- `s_valid_i`  in  1  producer has a byte.
- `s_ready_o`  out  1  block accepts the byte this cycle (valid & ready = handshake).
- `busy_o`  out  1  high in every state except IDLE.
- `scl_o`  out  1  SPI clock, mode 0 (idle low, sampled on rising edge).
- `mosi_o`  out  1  serial data.
- `cs_o`  out  1  chip select, active low.
- `dc_o`  out  1  D/C# line.
- `oled_rst_o`  out  1  panel RES#, active low.

## Operation
- States: RST_LOW → RST_WAIT → IDLE ↔ SHIFT → CS_HOLD → IDLE.
- RST_LOW: `oled_rst_o`=0 for RST_PULSE_CYCLES, then RST_WAIT with `oled_rst_o`=1 for RST_RECOVER_CYCLES, then IDLE.
- IDLE: `s_ready_o`=1, `cs_o`=1, `scl_o`=0.
  - On a handshake: latch the byte into the shift register, latch `s_dc_i` into `dc_o`, and go to SHIFT.
  - Otherwise, if `oled_init_i`=1, go to RST_LOW.
  - A handshake and `oled_init_i` in the same cycle: the byte wins and init is ignored, so the requester must hold it.
- SHIFT: 8 bits, each CLK_DIV cycles SCL low and then CLK_DIV cycles SCL high. MOSI changes only while SCL is low, on the first low cycle of each bit.
  - `s_ready_o`=1 only on the final cycle of bit 0's high phase.
  - Handshake on that cycle: reload the shifter and `dc_o`, and stay in SHIFT with no gap.
  - No handshake on that cycle: go to CS_HOLD.
- CS_HOLD: SCL low and CS low for CLK_DIV cycles, then IDLE with `cs_o`=1.
- `dc_o` and `mosi_o` hold their last values in IDLE.
- `oled_init_i` and `s_valid_i` are ignored outside the states above.

## Timing
- Reset values (while `rst_i`=0 and on the first cycle after): `scl_o`=0, `mosi_o`=0, `cs_o`=1, `dc_o`=0, `oled_rst_o`=0, `s_ready_o`=0, `busy_o`=1, state=RST_LOW with counter cleared.
- Handshake in IDLE at cycle T:
  - T+1: `cs_o`=0, `dc_o` valid, `mosi_o`=bit7, `scl_o`=0.
  - Rising edge k (k=0..7) at T+1+CLK_DIV+2k·CLK_DIV.
  - Last high cycle at T+16·CLK_DIV, with `s_ready_o`=1.
- Byte throughput during bursts is exactly 16·CLK_DIV cycles per byte.
- Lone byte: `cs_o` low from T+1 through T+17·CLK_DIV. `s_ready_o` is high again at T+17·CLK_DIV+1.
- Ready in IDLE is state-decoded and registered. Ready in SHIFT is decoded from the bit/phase counters, not combinational on inputs.
- Counters:
  - Phase counter: $clog2(CLK_DIV) bits.
  - Bit counter: 3 bits, wraps 0→7 on reload.
  - Reset timer: $clog2(max(RST_PULSE_CYCLES, RST_RECOVER_CYCLES)+1) bits, cleared on each state entry.
- `rst_i` low mid-byte aborts immediately: outputs take reset values next cycle, the partial byte is dropped, and the RES# sequence restarts.

## Structure
- Shared include `ssd1306-def.v` holds:
  - state encodings (`SSD1306_TX_RST_LOW` … `SSD1306_TX_CS_HOLD`);
  - the D/C# constants `SSD1306_DC_CMD`=0 and `SSD1306_DC_DATA`=1, shared with the `ssd1306` receiver.
- One natural sub-module, `ssd1306_spi_phase`: the CLK_DIV phase counter and bit counter, emitting `fall_en`, `rise_en` and `last_cycle` strobes. The FSM, shifter and reset timer stay in the top.

## Test plan
Bench parameters: CLK_DIV=2, RST_PULSE_CYCLES=4, RST_RECOVER_CYCLES=8.
1. Release `rst_i` at cycle 0 → `oled_rst_o`=0 for cycles 0–3 and 1 from cycle 4; `busy_o`=1 until IDLE; `s_ready_o` first high at cycle 12.
2. Single byte 0xA5, dc=0 → 8 rising edges 4 cycles apart; MOSI sampled at the edges = 1,0,1,0,0,1,0,1; `dc_o`=0; `cs_o` low for exactly 34 cycles.
3. Burst 0x3C (dc=1) then 0xC3 (dc=0), `s_valid_i` held → 16 contiguous SCL pulses with no extra low gap; `cs_o` never rises; `dc_o` switches 1→0 only while `scl_o`=0 before the 9th rising edge.
4. Backpressure: `s_valid_i` asserted mid-byte with 0x81 held → data is not accepted until the single `s_ready_o` cycle at byte end, then shifted out intact.
5. `rst_i` pulled low at the 4th rising edge → next cycle `cs_o`=1, `scl_o`=0, `oled_rst_o`=0; the receiver sees an incomplete byte and no spurious trailing edge.
6. In IDLE, `oled_init_i`=1 alone → the RES# sequence repeats as in scenario 1. `oled_init_i` and `s_valid_i` together → the byte is sent and no RES# pulse occurs.
